// File: rtl/vga_blinken_tiles_pkg.sv
// Shared constants for the blinking-tile colour stage: video timing,
// update FSM encoding, LFSR taps and the tile palette.
package vga_blinken_tiles_pkg;

  localparam int unsigned VGA_RES_H = 640;
  localparam int unsigned VGA_RES_V = 480;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } upd_state_e;

  // RGB332 tile colours, indexed by (tile index + phase) mod 8
  function automatic logic [7:0] palette_rgb(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hE0;
      3'd1:    c = 8'hFC;
      3'd2:    c = 8'h1C;
      3'd3:    c = 8'h1F;
      3'd4:    c = 8'h03;
      3'd5:    c = 8'hE3;
      3'd6:    c = 8'hF4;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_blinken_tiles_lfsr.sv
// 16-bit right-shifting Galois LFSR with zero-lock recovery.
module lfsr16_galois
  import vga_blinken_tiles_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        PIXEL_CLK,
  input  logic        RESET_N,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next state: escape the all-zero lock first, otherwise shift when asked
  always_comb begin
    state_d = state_q;
    if (state_q == 16'h0000) begin
      state_d = SEED;
    end else if (advance) begin
      state_d = {1'b0, state_q[15:1]} ^ (state_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // State register, reseeded on reset
  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/vga_blinken_tiles.sv
// Colour stage behind the VGA sync generator: draws a grid of blinking
// tiles with a 3-cycle pipeline and delay-matched syncs. Tile states are
// scrambled by an LFSR during vertical blanking every few frames.
module vga_blinken_tiles
  import vga_blinken_tiles_pkg::*;
#(
  parameter int unsigned TILE_LOG2       = 6,
  parameter int unsigned TILES_X         = 10,
  parameter int unsigned TILES_Y         = 8,
  parameter int unsigned FRAMES_PER_STEP = 30,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter logic [7:0]  GRID_COLOUR     = 8'h49
) (
  input  logic        PIXEL_CLK,
  input  logic        RESET_N,
  input  logic [12:0] locX,
  input  logic [12:0] locY,
  input  logic        in_image,
  input  logic        sync_h,
  input  logic        sync_v,
  output logic [7:0]  rgb,
  output logic        sync_h_out,
  output logic        sync_v_out,
  output logic        in_image_out
);

  localparam int unsigned COORD_W = 13;
  localparam int unsigned TILE_W  = COORD_W - TILE_LOG2;
  localparam int unsigned NTILES  = TILES_X * TILES_Y;
  localparam int unsigned IDX_W   = (NTILES > 8) ? $clog2(NTILES) : 3;

  // Stage 1 registers
  logic [TILE_W-1:0] tx1_q, tx1_d;
  logic [TILE_W-1:0] ty1_q, ty1_d;
  logic              grid1_q, grid1_d;
  logic              img1_q, img1_d;
  logic              hs1_q, hs1_d;
  logic              vs1_q, vs1_d;

  // Stage 2 registers
  logic              tile_on2_q, tile_on2_d;
  logic [2:0]        pal2_q, pal2_d;
  logic              grid2_q, grid2_d;
  logic              img2_q, img2_d;
  logic              hs2_q, hs2_d;
  logic              vs2_q, vs2_d;

  // Stage 3 (output) registers
  logic [7:0]        rgb3_q, rgb3_d;
  logic              img3_q, img3_d;
  logic              hs3_q, hs3_d;
  logic              vs3_q, vs3_d;

  // Tile update control
  upd_state_e        state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        cnt_q;
  logic [2:0]        phase_q;
  logic [NTILES-1:0] tiles_q;

  logic              frame_tick;
  logic              lfsr_adv;
  logic [15:0]       lfsr_state;
  logic              unused_lfsr_bits;

  logic [IDX_W-1:0]  tile_idx;
  logic              in_range;
  logic [IDX_W-1:0]  rd_idx;

  // First blanking line, first pixel: once-per-frame event
  assign frame_tick = (locX == 13'd0) && (locY == 13'(VGA_RES_V));
  assign lfsr_adv   = (state_q == UPDATE);

  lfsr16_galois #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .PIXEL_CLK(PIXEL_CLK),
    .RESET_N  (RESET_N),
    .advance  (lfsr_adv),
    .state    (lfsr_state)
  );

  assign unused_lfsr_bits = ^lfsr_state[15:1];

  // Pipeline next-state: tile coordinates, tile lookup, then colour select
  always_comb begin
    tx1_d   = locX[COORD_W-1:TILE_LOG2];
    ty1_d   = locY[COORD_W-1:TILE_LOG2];
    grid1_d = (locX[TILE_LOG2-1:0] == '0) | (locY[TILE_LOG2-1:0] == '0);
    img1_d  = in_image;
    hs1_d   = sync_h;
    vs1_d   = sync_v;

    in_range   = (16'(tx1_q) < 16'(TILES_X)) && (16'(ty1_q) < 16'(TILES_Y));
    tile_idx   = IDX_W'(ty1_q) * IDX_W'(TILES_X) + IDX_W'(tx1_q);
    rd_idx     = in_range ? tile_idx : '0;
    tile_on2_d = in_range & tiles_q[rd_idx];
    pal2_d     = tile_idx[2:0] + phase_q;
    grid2_d    = grid1_q;
    img2_d     = img1_q;
    hs2_d      = hs1_q;
    vs2_d      = vs1_q;

    rgb3_d = 8'h00;
    if (!img2_q) begin
      rgb3_d = 8'h00;
    end else if (grid2_q) begin
      rgb3_d = GRID_COLOUR;
    end else if (tile_on2_q) begin
      rgb3_d = palette_rgb(pal2_q);
    end
    img3_d = img2_q;
    hs3_d  = hs2_q;
    vs3_d  = vs2_q;
  end

  // Pipeline registers, all cleared on reset
  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx1_q      <= '0;
      ty1_q      <= '0;
      grid1_q    <= 1'b0;
      img1_q     <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      tile_on2_q <= 1'b0;
      pal2_q     <= 3'd0;
      grid2_q    <= 1'b0;
      img2_q     <= 1'b0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      rgb3_q     <= 8'h00;
      img3_q     <= 1'b0;
      hs3_q      <= 1'b0;
      vs3_q      <= 1'b0;
    end else begin
      tx1_q      <= tx1_d;
      ty1_q      <= ty1_d;
      grid1_q    <= grid1_d;
      img1_q     <= img1_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      tile_on2_q <= tile_on2_d;
      pal2_q     <= pal2_d;
      grid2_q    <= grid2_d;
      img2_q     <= img2_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      rgb3_q     <= rgb3_d;
      img3_q     <= img3_d;
      hs3_q      <= hs3_d;
      vs3_q      <= vs3_d;
    end
  end

  // Frame counting, phase stepping and the one-tile-per-cycle update walk
  always_ff @(posedge PIXEL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
      phase_q <= 3'd0;
      tiles_q <= '0;
    end else begin
      if (frame_tick) begin
        if (cnt_q == 8'(FRAMES_PER_STEP - 1)) begin
          cnt_q   <= 8'd0;
          phase_q <= phase_q + 3'd1;
          if (state_q == IDLE) begin
            state_q <= UPDATE;
            idx_q   <= '0;
          end
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      if (state_q == UPDATE) begin
        tiles_q[idx_q] <= tiles_q[idx_q] ^ lfsr_state[0];
        if (idx_q == IDX_W'(NTILES - 1)) begin
          state_q <= IDLE;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign rgb          = rgb3_q;
  assign sync_h_out   = hs3_q;
  assign sync_v_out   = vs3_q;
  assign in_image_out = img3_q;

endmodule

// File: tb/tb_vga_blinken_tiles.sv
// Directed self-checking bench for vga_blinken_tiles (FRAMES_PER_STEP = 2).
`timescale 1ns/1ps
module tb_vga_blinken_tiles;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] loc_x = '0;
  logic [12:0] loc_y = '0;
  logic        in_img = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [7:0]  rgb;
  logic        hs_o;
  logic        vs_o;
  logic        img_o;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pal [8];
  logic [79:0] tiles_m;
  logic [15:0] lfsr_m;
  logic [2:0]  phase_m;

   // Free-running 100 MHz pixel clock
  always #5 clk = ~clk;

  vga_blinken_tiles #(
    .FRAMES_PER_STEP(2)
  ) dut (
    .PIXEL_CLK   (clk),
    .RESET_N     (rst_n),
    .locX        (loc_x),
    .locY        (loc_y),
    .in_image    (in_img),
    .sync_h      (hs),
    .sync_v      (vs),
    .rgb         (rgb),
    .sync_h_out  (hs_o),
    .sync_v_out  (vs_o),
    .in_image_out(img_o)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s == 16'h0000) return 16'hACE1;
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int first_on_tile(input logic [79:0] t);
    for (int i = 0; i < 80; i++) if (t[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    tiles_m = '0;
    lfsr_m  = 16'hACE1;
    phase_m = 3'd0;
  endtask

  task automatic model_step();
    phase_m = phase_m + 3'd1;
    for (int i = 0; i < 80; i++) begin
      tiles_m[i] = tiles_m[i] ^ lfsr_m[0];
      lfsr_m = lfsr_step(lfsr_m);
    end
  endtask

  task automatic applyStimulus(input logic [12:0] x, input logic [12:0] y,
                               input logic img, input logic h, input logic v);
    loc_x = x; loc_y = y; in_img = img; hs = h; vs = v;
  endtask

  task automatic probe(input logic [12:0] x, input logic [12:0] y, input logic img,
                       input logic h, input logic v, output logic [7:0] r,
                       output logic [2:0] side);
    @(negedge clk);
    applyStimulus(x, y, img, h, v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    r = rgb;
    side = {hs_o, vs_o, img_o};
  endtask

  task automatic tick();
    @(negedge clk);
    applyStimulus(13'd0, 13'd480, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(13'd1, 13'd480, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_step();
    tick();
    tick();
    repeat (85) @(negedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(13'd5, 13'd5, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(13'd0, 13'd0, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({rgb, hs_o, vs_o, img_o} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 000", {rgb, hs_o, vs_o, img_o});
    end
    checks++;
    if (dut.tiles_q !== 80'h0) begin
      errors++;
      $display("[TB] FAIL reset_tiles: got %h expected 0", dut.tiles_q);
    end
    checks++;
    if (dut.u_lfsr.state_q !== 16'hACE1) begin
      errors++;
      $display("[TB] FAIL reset_lfsr: got %h expected ace1", dut.u_lfsr.state_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_grid();
    logic [12:0] xs [8] = '{13'd0, 13'd64, 13'd100, 13'd10, 13'd639, 13'd128, 13'd300, 13'd0};
    logic [12:0] ys [8] = '{13'd10, 13'd100, 13'd64, 13'd10, 13'd479, 13'd0, 13'd200, 13'd64};
    logic [2:0]  sd [8] = '{3'b001, 3'b101, 3'b011, 3'b001, 3'b001, 3'b111, 3'b001, 3'b000};
    logic [7:0]  ex [8] = '{8'h49, 8'h49, 8'h49, 8'h00, 8'h00, 8'h49, 8'h00, 8'h00};
    logic [7:0]  r;
    logic [2:0]  side;
    for (int i = 0; i < 8; i++) begin
      probe(xs[i], ys[i], sd[i][0], sd[i][2], sd[i][1], r, side);
      checks++;
      if (r !== ex[i]) begin
        errors++;
        $display("[TB] FAIL grid_rgb[%0d]: got %h expected %h", i, r, ex[i]);
      end
      checks++;
      if (side !== sd[i]) begin
        errors++;
        $display("[TB] FAIL grid_sync[%0d]: got %b expected %b", i, side, sd[i]);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    applyStimulus(13'd10, 13'd10, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(13'd10, 13'd10, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(13'd10, 13'd10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (hs_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: got %b expected 0", hs_o);
    end
    @(negedge clk);
    checks++;
    if (hs_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_3: got %b expected 1", hs_o);
    end
    @(negedge clk);
    checks++;
    if (hs_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_width: got %b expected 0", hs_o);
    end
  endtask

  task automatic test_update();
    logic [7:0] r;
    logic [2:0] side;
    int         t;
    tick();
    repeat (85) @(negedge clk);
    checks++;
    if (dut.tiles_q !== 80'h0) begin
      errors++;
      $display("[TB] FAIL update_one_tick: got %h expected 0", dut.tiles_q);
    end
    tick();
    repeat (85) @(negedge clk);
    model_step();
    checks++;
    if (dut.tiles_q !== tiles_m) begin
      errors++;
      $display("[TB] FAIL update_tiles: got %h expected %h", dut.tiles_q, tiles_m);
    end
    checks++;
    if (dut.u_lfsr.state_q !== lfsr_m) begin
      errors++;
      $display("[TB] FAIL update_lfsr: got %h expected %h", dut.u_lfsr.state_q, lfsr_m);
    end
    probe(13'd65, 13'd65, 1'b1, 1'b0, 1'b0, r, side);
    checks++;
    if (r !== (tiles_m[11] ? 8'h03 : 8'h00)) begin
      errors++;
      $display("[TB] FAIL tile11_rgb: got %h expected %h", r, tiles_m[11] ? 8'h03 : 8'h00);
    end
    t = first_on_tile(tiles_m);
    if (t >= 0) begin
      probe(13'((t % 10) * 64 + 32), 13'((t / 10) * 64 + 32), 1'b1, 1'b0, 1'b0, r, side);
      checks++;
      if (r !== pal[(t + 1) % 8]) begin
        errors++;
        $display("[TB] FAIL on_tile_rgb[%0d]: got %h expected %h", t, r, pal[(t + 1) % 8]);
      end
    end
    probe(13'd650, 13'd100, 1'b1, 1'b0, 1'b0, r, side);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("[TB] FAIL out_of_range_x: got %h expected 00", r);
    end
    probe(13'd100, 13'd520, 1'b1, 1'b0, 1'b0, r, side);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("[TB] FAIL out_of_range_y: got %h expected 00", r);
    end
  endtask

  task automatic test_reset_mid_update();
    tick();
    tick();
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (dut.idx_q !== 7'd40) begin
      errors++;
      $display("[TB] FAIL mid_index: got %0d expected 40", dut.idx_q);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut.tiles_q !== 80'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset_tiles: got %h expected 0", dut.tiles_q);
    end
    checks++;
    if (dut.u_lfsr.state_q !== 16'hACE1) begin
      errors++;
      $display("[TB] FAIL mid_reset_lfsr: got %h expected ace1", dut.u_lfsr.state_q);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_step();
    checks++;
    if (dut.tiles_q !== tiles_m) begin
      errors++;
      $display("[TB] FAIL fresh_update_tiles: got %h expected %h", dut.tiles_q, tiles_m);
    end
  endtask

  task automatic test_lfsr_zero();
    @(negedge clk);
    force dut.u_lfsr.state_q = 16'h0000;
    @(posedge clk);
    #1;
    release dut.u_lfsr.state_q;
    @(posedge clk);
    #1;
    checks++;
    if (dut.u_lfsr.state_q !== 16'hACE1) begin
      errors++;
      $display("[TB] FAIL lfsr_zero_reload: got %h expected ace1", dut.u_lfsr.state_q);
    end
  endtask

  task automatic test_phase_wrap();
    logic [7:0] r;
    logic [2:0] side;
    int         t;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      do_step();
      probe(13'd32, 13'd32, 1'b1, 1'b0, 1'b0, r, side);
      checks++;
      if (r !== (tiles_m[0] ? pal[phase_m] : 8'h00)) begin
        errors++;
        $display("[TB] FAIL tile0_step%0d: got %h expected %h", s, r,
                 tiles_m[0] ? pal[phase_m] : 8'h00);
      end
      t = first_on_tile(tiles_m);
      if (t >= 0) begin
        probe(13'((t % 10) * 64 + 32), 13'((t / 10) * 64 + 32), 1'b1, 1'b0, 1'b0, r, side);
        checks++;
        if (r !== pal[(t + int'(phase_m)) % 8]) begin
          errors++;
          $display("[TB] FAIL phase_tile%0d_step%0d: got %h expected %h", t, s, r,
                   pal[(t + int'(phase_m)) % 8]);
        end
      end
    end
    checks++;
    if (dut.phase_q !== 3'd0) begin
      errors++;
      $display("[TB] FAIL phase_wrap: got %0d expected 0", dut.phase_q);
    end
    checks++;
    if (dut.tiles_q !== tiles_m) begin
      errors++;
      $display("[TB] FAIL phase_wrap_tiles: got %h expected %h", dut.tiles_q, tiles_m);
    end
  endtask

   // Run every scenario in order, then report
  initial begin
    pal = '{8'hE0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hF4, 8'hFF};
    model_reset();
    test_reset();
    test_grid();
    test_latency();
    test_update();
    test_reset_mid_update();
    test_lfsr_zero();
    test_phase_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_blinken_tiles.md
Name: vga_blinken_tiles

Overview:
Pixel-colour stage directly downstream of the VGA sync generator. Consumes its pixel coordinates, active-image flag and raw syncs. Emits RGB332 colour plus delay-matched syncs for a grid of blinking tiles. Tile on/off state is held in an on-chip bit array and updated from a 16-bit LFSR during vertical blanking, once every FRAMES_PER_STEP frames.

Parameters:
TILE_LOG2, 6, tile edge = 2^TILE_LOG2 px (64 px)
TILES_X, 10, tile columns (640/64)
TILES_Y, 8, tile rows (last row partially visible at 480 lines)
FRAMES_PER_STEP, 30, frames between tile updates (1..255)
LFSR_SEED, 16'hACE1, LFSR reset/reload value (nonzero)
GRID_COLOUR, 8'h49, RGB332 colour of tile border lines

Ports:
PIXEL_CLK  in  1  pixel clock, sole clock
RESET_N  in  1  asynchronous active-low reset
locX  in  13  current pixel column from sync generator
locY  in  13  current pixel row from sync generator
in_image  in  1  high while (locX,locY) is in visible area
sync_h  in  1  horizontal sync, raw from generator
sync_v  in  1  vertical sync, raw from generator
rgb  out  8  RGB332 colour {R[2:0],G[2:0],B[1:0]}
sync_h_out  out  1  sync_h delayed to align with rgb
sync_v_out  out  1  sync_v delayed to align with rgb
in_image_out  out  1  in_image delayed to align with rgb

Behaviour:
- Reset (RESET_N low, async): rgb=0, sync_h_out=0, sync_v_out=0, in_image_out=0. All pipeline registers 0. Tile array all off. LFSR=LFSR_SEED. Frame counter=0, phase=0, FSM=IDLE. Release is synchronous to PIXEL_CLK.
- Pipeline: fixed latency 3 PIXEL_CLK cycles. Inputs sampled at edge N appear on all four outputs at edge N+3. Syncs and in_image pass through a 3-deep shift register, with no logic applied.
- S1: register tx=locX>>TILE_LOG2, ty=locY>>TILE_LOG2, grid flag = (locX[TILE_LOG2-1:0]==0)|(locY[TILE_LOG2-1:0]==0), in_image.
- S2: tile_idx=ty*TILES_X+tx. Read tile bit; bit is 0 if tx>=TILES_X or ty>=TILES_Y. Palette index=(tile_idx+phase) mod 8.
- S3 colour priority: !in_image -> 0; grid -> GRID_COLOUR; tile on -> PALETTE[index]; else 0.
- Frame tick: one-cycle pulse when locX==0 && locY==VGA_RES_V, i.e. the first blanking line.
  - On tick: frame counter increments.
  - When the counter equals FRAMES_PER_STEP-1 at tick: counter->0, phase increments (3-bit wrap 7->0), FSM IDLE->UPDATE.
- FSM states:
  - IDLE: wait for step tick.
  - UPDATE: one tile per cycle, index i=0..TILES_X*TILES_Y-1. tile[i] ^= lfsr[0], and the LFSR advances one step. After the last index, go to IDLE. Takes 80 cycles, well inside vblank.
  - A frame tick arriving during UPDATE is still counted, but cannot start a new update; the pending step is dropped.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400. If the state is ever 0, reload LFSR_SEED on the next cycle.
- Tile array write port is active only in UPDATE. It is read-only for the pixel path. Reads during vblank are don't-care because in_image=0 forces black.
- Reset mid-UPDATE aborts immediately: tiles cleared, LFSR reseeded.

Decomposition:
- Shared include lib/blinken_palette.v:
  - 8-entry PALETTE RGB332 constants: 8'hE0, 8'hFC, 8'h1C, 8'h1F, 8'h03, 8'hE3, 8'hF4, 8'hFF.
  - FSM state encodings IDLE=1'b0, UPDATE=1'b1.
  - Reuses VGA_RES_H/VGA_RES_V from lib/vga_timing.v.
- One sub-module, lfsr16_galois, with ports PIXEL_CLK, RESET_N, advance, state[15:0], SEED parameter, and zero-lock recovery.

Test Plan:
1. Reset then stream one full frame with all tiles off. Expect rgb=GRID_COLOUR at (0,y), (64,y) and (x,64). Expect rgb=0 elsewhere in image. Expect outputs = inputs delayed exactly 3 cycles.
2. Drive sync_h high at cycle 100 -> sync_h_out high at cycle 103. Drive in_image=0 with grid coordinates -> rgb=0.
3. Run FRAMES_PER_STEP=2 for two frames. Check the tile array against a reference LFSR model (seed 16'hACE1, mask 16'hB400) after 80 update cycles. Check that pixel (65,65), tile 11, shows PALETTE[(11+1) mod 8]=8'h03 if that tile is on.
4. Assert RESET_N low for 1 cycle at update index 40 -> all tiles 0 and LFSR=16'hACE1 immediately. Next step starts a fresh update from index 0.
5. Force the LFSR to 0 via backdoor -> state 16'hACE1 next cycle.
6. Phase wrap: run 8 steps -> phase returns to 0, tile 0 colour cycles through all 8 palette entries in order.
